// File: rtl/cond_flag_unit_if.sv
// Flag-update / condition-evaluation bundle between ALU writeback, issue and the flag unit.
interface cond_flag_unit_if #(
    parameter int NUM_CH = 1
);
    logic                  in_flags_we;
    logic [3:0]            in_flags_mask;
    logic [3:0]            in_flags;
    logic                  in_stall;
    logic [NUM_CH-1:0]     in_ch_valid;
    logic [4*NUM_CH-1:0]   in_ch_cond;
    logic [3:0]            out_flags;
    logic [NUM_CH-1:0]     out_ch_valid;
    logic [NUM_CH-1:0]     out_execute_en;

    modport master (
        output in_flags_we, in_flags_mask, in_flags, in_stall,
        output in_ch_valid, in_ch_cond,
        input  out_flags, out_ch_valid, out_execute_en
    );

    modport slave (
        input  in_flags_we, in_flags_mask, in_flags, in_stall,
        input  in_ch_valid, in_ch_cond,
        output out_flags, out_ch_valid, out_execute_en
    );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV flag register plus NUM_CH parallel ARM condition evaluators.
// Define COND_FLAG_BYPASS_EN to let a same-cycle flag write feed evaluation.
module cond_flag_unit #(
    parameter int         NUM_CH     = 1,
    parameter bit         REG_OUT    = 1'b1,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             in_clk,
    input  logic             in_rst,
    cond_flag_unit_if.slave  bus
);
    logic [3:0]        flags_q;
    logic [3:0]        flags_d;
    logic [3:0]        eval_f;
    logic [NUM_CH-1:0] res;

    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        flags_d = flags_q;
        if (bus.in_flags_we) begin
            flags_d = (bus.in_flags & bus.in_flags_mask)
                    | (flags_q & ~bus.in_flags_mask);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            flags_q <= FLAG_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    // flags_d already is the merged write value, so it doubles as the bypass
`ifdef COND_FLAG_BYPASS_EN
    assign eval_f = flags_d;
`else
    assign eval_f = flags_q;
`endif

    always_comb begin
        res = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            res[i] = bus.in_ch_valid[i]
                   & cond_pass(bus.in_ch_cond[4*i +: 4], eval_f);
        end
    end

    assign bus.out_flags = flags_q;

    generate
        if (REG_OUT) begin : g_reg
            logic [NUM_CH-1:0] valid_q;
            logic [NUM_CH-1:0] valid_d;
            logic [NUM_CH-1:0] exec_q;
            logic [NUM_CH-1:0] exec_d;

            always_comb begin
                valid_d = valid_q;
                exec_d  = exec_q;
                if (!bus.in_stall) begin
                    valid_d = bus.in_ch_valid;
                    exec_d  = res;
                end
            end

            always_ff @(posedge in_clk or posedge in_rst) begin
                if (in_rst) begin
                    valid_q <= '0;
                    exec_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    exec_q  <= exec_d;
                end
            end

            assign bus.out_ch_valid   = valid_q;
            assign bus.out_execute_en = exec_q;
        end else begin : g_comb
            assign bus.out_ch_valid   = bus.in_ch_valid;
            assign bus.out_execute_en = res;
        end
    endgenerate
endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomized and directed bench for cond_flag_unit (NUM_CH=4, REG_OUT=1).
module tb_cond_flag_unit;
    localparam int         NCH  = 4;
    localparam logic [3:0] FRST = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    cond_flag_unit_if #(.NUM_CH(NCH)) bus ();

    cond_flag_unit #(
        .NUM_CH(NCH), .REG_OUT(1'b1), .FLAG_RESET(FRST)
    ) dut (
        .in_clk(clk), .in_rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: conditions come in predicate/inverse pairs selected by cond[3:1]
    function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        return cond[0] ? !r : r;
    endfunction

    logic [3:0]     m_flags;
    logic [NCH-1:0] m_valid;
    logic [NCH-1:0] m_exec;

    always @(posedge clk or posedge rst) begin
        logic [3:0] f;
        logic [3:0] nf;
        logic [3:0] cnd;
        if (rst) begin
            m_flags = FRST;
            m_valid = '0;
            m_exec  = '0;
        end else begin
            nf = m_flags;
            if (bus.in_flags_we)
                for (int k = 0; k < 4; k++)
                    if (bus.in_flags_mask[k]) nf[k] = bus.in_flags[k];
`ifdef COND_FLAG_BYPASS_EN
            f = nf;
`else
            f = m_flags;
`endif
            if (!bus.in_stall) begin
                m_valid = bus.in_ch_valid;
                for (int i = 0; i < NCH; i++) begin
                    cnd = bus.in_ch_cond[4*i +: 4];
                    m_exec[i] = bus.in_ch_valid[i] && ref_pass(cnd, f);
                end
            end
            m_flags = nf;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks += 3;
            if (bus.out_flags !== m_flags) begin
                errors++;
                $display("FAIL model_flags t=%0t act=%b exp=%b", $time, bus.out_flags, m_flags);
            end
            if (bus.out_ch_valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t act=%b exp=%b", $time, bus.out_ch_valid, m_valid);
            end
            if (bus.out_execute_en !== m_exec) begin
                errors++;
                $display("FAIL model_exec t=%0t act=%b exp=%b", $time, bus.out_execute_en, m_exec);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic we, input logic [3:0] mask, input logic [3:0] fl,
                          input logic [NCH-1:0] vld, input logic [15:0] cond,
                          input logic stall);
        bus.in_flags_we   = we;
        bus.in_flags_mask = mask;
        bus.in_flags      = fl;
        bus.in_ch_valid   = vld;
        bus.in_ch_cond    = cond;
        bus.in_stall      = stall;
    endtask

    task automatic wr_flags(input logic [3:0] mask, input logic [3:0] fl);
        set_in(1'b1, mask, fl, '0, '0, 1'b0);
        step();
        bus.in_flags_we = 1'b0;
    endtask

    initial begin
        logic [3:0] held_exec;
        logic [3:0] held_valid;
        logic       byp_exp;
        set_in(1'b0, '0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {4'b0, bus.out_flags}, 8'h00);
        chk("rst_valid", {4'b0, bus.out_ch_valid}, 8'h00);
        chk("rst_exec",  {4'b0, bus.out_execute_en}, 8'h00);
        rst = 1'b0;
        cmp_en = 1'b1;

        set_in(1'b0, '0, '0, 4'b0001, 16'h000E, 1'b0);
        step();
        chk("al_exec", {4'b0, bus.out_execute_en}, 8'h01);
        bus.in_ch_cond = 16'h000F;
        step();
        chk("nv_exec", {4'b0, bus.out_execute_en}, 8'h00);
        chk("nv_valid", {4'b0, bus.out_ch_valid}, 8'h01);

        wr_flags(4'hF, 4'b0100);
        chk("z_flags", {4'b0, bus.out_flags}, 8'h04);
        set_in(1'b0, '0, '0, 4'b1111, 16'h8910, 1'b0);
        step();
        chk("eq_ne_ls_hi", {4'b0, bus.out_execute_en}, 8'h05);
        set_in(1'b0, '0, '0, 4'b0011, 16'h00DC, 1'b0);
        step();
        chk("gt_le", {4'b0, bus.out_execute_en}, 8'h02);

        wr_flags(4'hF, 4'b1001);
        set_in(1'b0, '0, '0, 4'b0111, 16'h0CBA, 1'b0);
        step();
        chk("ge_lt_gt", {4'b0, bus.out_execute_en}, 8'h05);
        wr_flags(4'b1000, 4'b0000);
        chk("mask_hold", {4'b0, bus.out_flags}, 8'h01);
        set_in(1'b0, '0, '0, 4'b0011, 16'h00BA, 1'b0);
        step();
        chk("ge_lt_after", {4'b0, bus.out_execute_en}, 8'h02);

        wr_flags(4'hF, 4'b0100);
        set_in(1'b0, '0, '0, 4'b1101, 16'hFE10, 1'b0);
        step();
        chk("four_ch", {4'b0, bus.out_execute_en}, 8'h05);

        held_exec  = bus.out_execute_en;
        held_valid = bus.out_ch_valid;
        set_in(1'b0, '0, '0, 4'b0010, 16'h00E0, 1'b1);
        step();
        bus.in_ch_valid = 4'b1000;
        bus.in_ch_cond  = 16'hE000;
        step();
        chk("stall_exec", {4'b0, bus.out_execute_en}, {4'b0, held_exec});
        chk("stall_valid", {4'b0, bus.out_ch_valid}, {4'b0, held_valid});
        bus.in_stall = 1'b0;
        step();
        chk("unstall_exec", {4'b0, bus.out_execute_en}, 8'h08);

        wr_flags(4'hF, 4'b0000);
`ifdef COND_FLAG_BYPASS_EN
        byp_exp = 1'b1;
`else
        byp_exp = 1'b0;
`endif
        set_in(1'b1, 4'hF, 4'b0100, 4'b0001, 16'h0000, 1'b0);
        step();
        chk("same_cyc_eq", {7'b0, bus.out_execute_en[0]}, {7'b0, byp_exp});
        set_in(1'b1, 4'hF, 4'b1111, 4'b0001, 16'h000E, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_flags", {4'b0, bus.out_flags}, {4'b0, FRST});
        chk("midrst_exec", {4'b0, bus.out_execute_en}, 8'h00);
        step();
        chk("midrst_hold", {4'b0, bus.out_flags}, {4'b0, FRST});
        rst = 1'b0;

        for (int t = 0; t < 600; t++) begin
            set_in($urandom_range(0, 1), 4'($urandom), 4'($urandom),
                   4'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
            rst = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
